// File: rtl/alu_op_issuer.sv
// -----------------------------------------------------------------------------
// Module : alu_op_issuer
// Purpose: Initiator side of the ALU opcode interface. Host opcode words
//          {acc, B[7:0], A[7:0], op[3:0]} are queued in a small FIFO. Each one
//          is issued to the ALU control block with a single-cycle en pulse.
//          After a fixed ALU latency the 8-bit answer is captured and offered
//          to a consumer with a valid/ready handshake.
//
// Parameters:
//   DEPTH    command FIFO entries (power of two, >= 2)
//   ALU_LAT  clocks from the en pulse to a valid ans_in (>= 1)
//
// Ports:
//   clk_in         in   1   rising-edge clock
//   rst_n_in       in   1   asynchronous active-low reset
//   cmd_valid_in   in   1   host offers cmd_data_in
//   cmd_ready_out  out  1   FIFO not full (push when valid && ready)
//   cmd_data_in    in   21  opcode word {acc, B, A, op}
//   opcode_out     out  21  opcode to ALU, held from one issue to the next
//   en_out         out  1   ALU enable, one cycle per command
//   ans_in         in   8   ALU answer
//   res_valid_out  out  1   result register occupied
//   res_ready_in   in   1   consumer accepts (pop when valid && ready)
//   res_data_out   out  8   captured answer
//   res_op_out     out  4   op field of the command that produced the answer
//   busy_out       out  1   FSM active or FIFO not empty
//   done_cnt_out   out  16  completed-command counter (only with macro)
//
// Optional feature macro: ALU_ISSUE_COUNT_EN
//   When defined, done_cnt_out counts CAPTURE cycles and wraps at 16 bits.
// -----------------------------------------------------------------------------
module alu_op_issuer #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        cmd_valid_in,
    output logic        cmd_ready_out,
    input  logic [20:0] cmd_data_in,
    output logic [20:0] opcode_out,
    output logic        en_out,
    input  logic [7:0]  ans_in,
    output logic        res_valid_out,
    input  logic        res_ready_in,
    output logic [7:0]  res_data_out,
    output logic [3:0]  res_op_out,
    output logic        busy_out
`ifdef ALU_ISSUE_COUNT_EN
    ,
    output logic [15:0] done_cnt_out
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic            w_issueStart;

    logic [20:0]     r_mem [DEPTH];
    logic [AW:0]     r_wrPtr;
    logic [AW:0]     r_rdPtr;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;

    logic [CW-1:0]   r_waitCnt;
    logic [20:0]     r_opcode;
    logic            r_en;
    logic            r_resValid;
    logic [7:0]      r_resData;
    logic [3:0]      r_resOp;

    // Pointers carry one extra MSB so equal low bits with differing MSBs
    // means full, fully equal means empty. Readiness uses the pre-pop
    // state, so a full FIFO refuses a push even in a cycle that pops.
    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                     (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_push  = cmd_valid_in && !w_full;
    assign w_pop   = (r_state == ST_ISSUE);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wrPtr[AW-1:0]] <= cmd_data_in;
        end
    end

    // A new issue waits until the result register is free, which is what
    // provides backpressure from the consumer all the way to the FIFO.
    always_comb begin
        w_nextState  = r_state;
        w_issueStart = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !r_resValid) begin
                    w_nextState  = ST_ISSUE;
                    w_issueStart = 1'b1;
                end
            end
            ST_ISSUE: begin
                w_nextState = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_waitCnt == WAIT_LAST) begin
                    w_nextState = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // opcode_out and en_out are loaded on the edge entering ISSUE, so the
    // pulse lines up with the ISSUE cycle and the opcode then stays put
    // until the next command is issued.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= ST_IDLE;
            r_en      <= 1'b0;
            r_opcode  <= '0;
            r_waitCnt <= '0;
        end else begin
            r_state <= w_nextState;
            r_en    <= w_issueStart;
            if (w_issueStart) begin
                r_opcode <= r_mem[r_rdPtr[AW-1:0]];
            end
            if (r_state == ST_WAIT) begin
                r_waitCnt <= r_waitCnt + 1'b1;
            end else begin
                r_waitCnt <= '0;
            end
        end
    end

    // Result register: loaded in CAPTURE, held until the consumer takes it.
    // CAPTURE can only be reached with the register empty, so load and
    // drain never collide.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_resValid <= 1'b0;
            r_resData  <= '0;
            r_resOp    <= '0;
        end else if (r_state == ST_CAPTURE) begin
            r_resValid <= 1'b1;
            r_resData  <= ans_in;
            r_resOp    <= r_opcode[3:0];
        end else if (r_resValid && res_ready_in) begin
            r_resValid <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_COUNT_EN
    logic [15:0] r_doneCnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_doneCnt <= '0;
        end else if (r_state == ST_CAPTURE) begin
            r_doneCnt <= r_doneCnt + 16'd1;
        end
    end

    assign done_cnt_out = r_doneCnt;
`endif

    assign cmd_ready_out = !w_full;
    assign opcode_out    = r_opcode;
    assign en_out        = r_en;
    assign res_valid_out = r_resValid;
    assign res_data_out  = r_resData;
    assign res_op_out    = r_resOp;
    assign busy_out      = (r_state != ST_IDLE) || !w_empty;

endmodule
